// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR tap table (3..32 bits), checker state encoding
// and a counter-width helper. Used by both the pattern generator and checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Bit (t-1) is set for every feedback tap t of a maximal-length XNOR LFSR.
  function automatic logic [31:0] tap_mask(input int num_bits);
    case (num_bits)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_predict.sv
// Next-bit predictor: XNOR of the history tap positions. The generator uses the
// same block so both ends share a single polynomial source.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 22
) (
  input  logic [NUM_BITS-1:0] history,
  output logic                predicted
);

  localparam logic [31:0]         TAP_MASK = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS     = TAP_MASK[NUM_BITS-1:0];

  // history[0] is the newest bit, so tap t sits at history[t-1].
  assign predicted = ~^(history & TAPS);

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for an XNOR-LFSR bit stream with lock/error flags.
// Optional macro LFSR_CHECK_STATS_EN adds o_Bit_Count for BER readout.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS      = 22,
  parameter int LOCK_COUNT    = 64,
  parameter int WINDOW        = 256,
  parameter int LOSS_LIMIT    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_DV,
  input  logic                     i_Data,
  input  logic                     i_Clear_Count,
  output logic                     o_Locked,
  output logic                     o_Error_Pulse,
`ifdef LFSR_CHECK_STATS_EN
  output logic [31:0]              o_Bit_Count,
`endif
  output logic [ERR_CNT_WIDTH-1:0] o_Error_Count
);

  localparam int FILL_W  = cnt_width(NUM_BITS);
  localparam int MATCH_W = cnt_width(LOCK_COUNT);
  localparam int WBIT_W  = cnt_width(WINDOW - 1);
  localparam int WERR_W  = cnt_width(LOSS_LIMIT);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(NUM_BITS - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  LOSS_CNT   = WERR_W'(LOSS_LIMIT);

  state_t                   state, state_nxt;
  logic [NUM_BITS-1:0]      hist, hist_nxt;
  logic [FILL_W-1:0]        fill_cnt, fill_nxt;
  logic [MATCH_W-1:0]       match_cnt, match_nxt;
  logic [WBIT_W-1:0]        wbit_cnt, wbit_nxt;
  logic [WERR_W-1:0]        werr_cnt, werr_nxt, werr_sum;
  logic [ERR_CNT_WIDTH-1:0] err_nxt;
  logic                     pulse_nxt;
  logic                     predicted;
  logic                     mismatch;

  lfsr_predict #(.NUM_BITS(NUM_BITS)) u_predict (
    .history   (hist),
    .predicted (predicted)
  );

  assign mismatch = i_Data ^ predicted;
  assign werr_sum = werr_cnt + WERR_W'(mismatch);
  assign o_Locked = (state == LOCKED);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill_cnt;
    match_nxt = match_cnt;
    wbit_nxt  = wbit_cnt;
    werr_nxt  = werr_cnt;
    err_nxt   = o_Error_Count;
    pulse_nxt = 1'b0;

    if (i_DV) begin
      case (state)
        SEARCH: begin
          hist_nxt = {hist[NUM_BITS-2:0], i_Data};
          fill_nxt = fill_cnt + 1'b1;
          if (fill_cnt == FILL_LAST) begin
            state_nxt = VERIFY;
            match_nxt = '0;
          end
        end

        VERIFY: begin
          hist_nxt = {hist[NUM_BITS-2:0], i_Data};
          if (mismatch) begin
            state_nxt = SEARCH;
            fill_nxt  = FILL_LAST;
          end else if (&hist) begin
            // All-ones is the XNOR lockup state (or a stuck-high line): never lock on it.
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              state_nxt = LOCKED;
              wbit_nxt  = '0;
              werr_nxt  = '0;
            end
          end
        end

        LOCKED: begin
          // Flywheel on the prediction so one corrupted bit is counted exactly once.
          hist_nxt  = {hist[NUM_BITS-2:0], predicted};
          pulse_nxt = mismatch;
          if (mismatch && !(&o_Error_Count))
            err_nxt = o_Error_Count + 1'b1;

          if (werr_sum == LOSS_CNT) begin
            state_nxt = SEARCH;
            hist_nxt  = '0;
            fill_nxt  = '0;
            wbit_nxt  = '0;
            werr_nxt  = '0;
          end else if (wbit_cnt == WBIT_LAST) begin
            wbit_nxt = '0;
            werr_nxt = '0;
          end else begin
            wbit_nxt = wbit_cnt + 1'b1;
            werr_nxt = werr_sum;
          end
        end

        default: state_nxt = SEARCH;
      endcase
    end

    if (i_Clear_Count)
      err_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= SEARCH;
      hist          <= '0;
      fill_cnt      <= '0;
      match_cnt     <= '0;
      wbit_cnt      <= '0;
      werr_cnt      <= '0;
      o_Error_Count <= '0;
      o_Error_Pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      hist          <= hist_nxt;
      fill_cnt      <= fill_nxt;
      match_cnt     <= match_nxt;
      wbit_cnt      <= wbit_nxt;
      werr_cnt      <= werr_nxt;
      o_Error_Count <= err_nxt;
      o_Error_Pulse <= pulse_nxt;
    end
  end

`ifdef LFSR_CHECK_STATS_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear_Count)
      o_Bit_Count <= '0;
    else if (i_DV && (state == LOCKED) && !(&o_Bit_Count))
      o_Bit_Count <= o_Bit_Count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker (NUM_BITS=7, LOCK_COUNT=16, ERR_CNT_WIDTH=4).
// Reference stream comes from an independent x^7+x^6+1 XNOR generator model.
module tb_lfsr_stream_checker;

  localparam int NB      = 7;
  localparam int LC      = 16;
  localparam int WIN     = 256;
  localparam int LL      = 32;
  localparam int ECW     = 4;
  localparam int LOCK_AT = NB + LC;

  logic           i_Clk = 1'b0;
  logic           i_Reset;
  logic           i_DV;
  logic           i_Data;
  logic           i_Clear_Count;
  logic           o_Locked;
  logic           o_Error_Pulse;
  logic [ECW-1:0] o_Error_Count;
`ifdef LFSR_CHECK_STATS_EN
  logic [31:0]    o_Bit_Count;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  logic [NB-1:0] gen_hist = '0;

  always #5 i_Clk = ~i_Clk;

  lfsr_stream_checker #(
    .NUM_BITS      (NB),
    .LOCK_COUNT    (LC),
    .WINDOW        (WIN),
    .LOSS_LIMIT    (LL),
    .ERR_CNT_WIDTH (ECW)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_DV          (i_DV),
    .i_Data        (i_Data),
    .i_Clear_Count (i_Clear_Count),
    .o_Locked      (o_Locked),
    .o_Error_Pulse (o_Error_Pulse),
`ifdef LFSR_CHECK_STATS_EN
    .o_Bit_Count   (o_Bit_Count),
`endif
    .o_Error_Count (o_Error_Count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // b[n] = XNOR(b[n-7], b[n-6]); gen_hist[0] is the newest bit.
  task automatic gen(output logic b);
    b        = ~(gen_hist[6] ^ gen_hist[5]);
    gen_hist = {gen_hist[5:0], b};
  endtask

  // Drive one cycle of input, then sample 1 time unit after the active edge.
  task automatic push(input logic dv, input logic d);
    i_DV   = dv;
    i_Data = d;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    logic b;
    logic flip;
    logic rnd;
    logic dv;
    int   exp_cnt;
    int   mism_cnt;
    int   acc;

    i_Reset       = 1'b1;
    i_DV          = 1'b0;
    i_Data        = 1'b0;
    i_Clear_Count = 1'b0;
    @(posedge i_Clk);
    #1;
    push(1'b1, 1'b1);
    check("rst_locked", 32'(o_Locked), 32'd0);
    check("rst_pulse",  32'(o_Error_Pulse), 32'd0);
    check("rst_count",  32'(o_Error_Count), 32'd0);
`ifdef LFSR_CHECK_STATS_EN
    check("rst_bitcnt", o_Bit_Count, 32'd0);
`endif
    i_Reset = 1'b0;

    // Clean stream with a single corrupted bit at 300; lock after bit 23.
    for (int k = 1; k <= 599; k++) begin
      gen(b);
      push(1'b1, (k == 300) ? ~b : b);
      check("lock_rise", 32'(o_Locked), 32'(k >= LOCK_AT));
      check("single_pulse", 32'(o_Error_Pulse), 32'(k == 300));
      check("single_count", 32'(o_Error_Count), (k >= 300) ? 32'd1 : 32'd0);
    end

    // Clear coincident with a mismatch: count clears, pulse still fires.
    gen(b);
    i_Clear_Count = 1'b1;
    push(1'b1, ~b);
    i_Clear_Count = 1'b0;
    check("clr_pulse",  32'(o_Error_Pulse), 32'd1);
    check("clr_count",  32'(o_Error_Count), 32'd0);
    check("clr_locked", 32'(o_Locked), 32'd1);

    // 20 consecutive errors saturate the 4-bit counter at 15.
    exp_cnt = 0;
    for (int k = 601; k <= 640; k++) begin
      flip = (k <= 620);
      gen(b);
      push(1'b1, b ^ flip);
      if (flip && exp_cnt < 15) exp_cnt++;
      check("sat_count",  32'(o_Error_Count), 32'(exp_cnt));
      check("sat_pulse",  32'(o_Error_Pulse), 32'(flip));
      check("sat_locked", 32'(o_Locked), 32'd1);
    end

    for (int k = 641; k <= 999; k++) begin
      gen(b);
      push(1'b1, b);
      check("clean_locked", 32'(o_Locked), 32'd1);
      check("clean_pulse",  32'(o_Error_Pulse), 32'd0);
    end

    // Window 792..1047: 31 errors hold lock; the 32nd on the wrap bit drops it.
    for (int k = 1000; k <= 1047; k++) begin
      flip = (k <= 1030) || (k == 1047);
      gen(b);
      push(1'b1, b ^ flip);
      check("win_locked", 32'(o_Locked), 32'(k != 1047));
      check("win_pulse",  32'(o_Error_Pulse), 32'(flip));
      check("win_count",  32'(o_Error_Count), 32'd15);
    end

    for (int j = 1; j <= LOCK_AT; j++) begin
      gen(b);
      push(1'b1, b);
      check("relock1", 32'(o_Locked), 32'(j >= LOCK_AT));
      check("relock1_pulse", 32'(o_Error_Pulse), 32'd0);
    end

    // Random data while locked: lock falls on the 32nd mismatch.
    mism_cnt = 0;
    for (int j = 0; j < WIN; j++) begin
      rnd = 1'($urandom_range(0, 1));
      gen(b);
      if (rnd != b) mism_cnt++;
      push(1'b1, rnd);
      check("rand_locked", 32'(o_Locked), 32'(mism_cnt < LL));
      check("rand_pulse",  32'(o_Error_Pulse), 32'(rnd != b));
      if (mism_cnt >= LL) break;
    end
    check("rand_count", 32'(o_Error_Count), 32'd15);

    for (int j = 1; j <= LOCK_AT; j++) begin
      gen(b);
      push(1'b1, b);
      check("relock2", 32'(o_Locked), 32'(j >= LOCK_AT));
    end

    // Reset while locked with a pulse pending.
    gen(b);
    push(1'b1, ~b);
    check("pre_rst_pulse", 32'(o_Error_Pulse), 32'd1);
    i_Reset = 1'b1;
    gen(b);
    push(1'b1, ~b);
    check("mid_rst_locked", 32'(o_Locked), 32'd0);
    check("mid_rst_pulse",  32'(o_Error_Pulse), 32'd0);
    check("mid_rst_count",  32'(o_Error_Count), 32'd0);
    i_Reset = 1'b0;

    // Gapped i_DV: timing counts accepted bits only.
    acc = 0;
    for (int c = 0; c < 2000 && acc < 330; c++) begin
      dv = 1'($urandom_range(0, 1));
      if (dv) begin
        acc++;
        gen(b);
        push(1'b1, (acc == 300) ? ~b : b);
      end else begin
        push(1'b0, 1'($urandom_range(0, 1)));
      end
      check("gap_locked", 32'(o_Locked), 32'(acc >= LOCK_AT));
      check("gap_pulse",  32'(o_Error_Pulse), 32'(dv && acc == 300));
      check("gap_count",  32'(o_Error_Count), (acc >= 300) ? 32'd1 : 32'd0);
    end
    check("gap_progress", 32'(acc >= 330), 32'd1);

    // Stuck-high input must never lock.
    i_Reset = 1'b1;
    push(1'b0, 1'b0);
    i_Reset = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      push(1'b1, 1'b1);
      check("stuck_locked", 32'(o_Locked), 32'd0);
    end
    check("stuck_pulse", 32'(o_Error_Pulse), 32'd0);
    check("stuck_count", 32'(o_Error_Count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
